// File: rtl/ps2_rx_frontend.sv
// ----------------------------------------------------------------------------
// ps2_rx_frontend
//   Device-to-host PS/2 keyboard receiver front end.
//   - Each raw PS/2 line is synchronised through SYNC_STAGES flops.
//   - The synced PS/2 clock is deglitched: it must stay different from the
//     filtered clock for FILTER_LEN consecutive cycles before the filtered
//     clock flips.
//   - Every 1->0 transition of the filtered clock is a sample event. On that
//     event the synced data line is fed to a small frame FSM
//     (start, 8 data bits LSB-first, odd parity, stop).
//   - A good frame updates SCAN_CODE and pulses SCAN_VALID. A bad frame
//     pulses PARITY_ERR or FRAME_ERR instead. A stalled frame also pulses
//     FRAME_ERR. All three pulses are registered and last one cycle.
//
// Ports
//   CLK_25MHZ  in   system clock; all logic runs on its rising edge
//   RESET      in   synchronous, active-high reset
//   PS2_CLK    in   raw PS/2 clock (asynchronous, idle high)
//   PS2_DATA   in   raw PS/2 data  (asynchronous, idle high)
//   SCAN_CODE  out  last correctly received byte
//   SCAN_VALID out  one-cycle pulse, SCAN_CODE has just been updated
//   PARITY_ERR out  one-cycle pulse, frame dropped for bad odd parity
//   FRAME_ERR  out  one-cycle pulse, frame dropped for stop bit 0 or timeout
// ----------------------------------------------------------------------------
module ps2_rx_frontend #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] SCAN_CODE,
    output logic       SCAN_VALID,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers. Reset to 1 so that an idle bus looks idle straight
    // out of reset.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_synced;
    logic                   data_synced;

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], PS2_CLK};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], PS2_DATA};
        end
    end

    assign clk_synced  = clk_sync_reg[SYNC_STAGES-1];
    assign data_synced = data_sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Clock deglitch filter and falling-edge sample event.
    // The filtered clock flips on the cycle the run of differing samples
    // reaches FILTER_LEN. The sample event is registered in that same
    // cycle when the flip goes 1->0, so the FSM sees a one-cycle strobe
    // on the following cycle.
    // ------------------------------------------------------------------
    logic [FW-1:0] filt_cnt_reg;
    logic          filt_clk_reg;
    logic          fall_reg;
    logic          filt_flip;

    assign filt_flip = (clk_synced != filt_clk_reg) &&
                       (filt_cnt_reg == FW'(FILTER_LEN - 1));

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            filt_cnt_reg <= '0;
            filt_clk_reg <= 1'b1;
            fall_reg     <= 1'b0;
        end else begin
            fall_reg <= filt_flip && filt_clk_reg;
            if (clk_synced == filt_clk_reg || filt_flip) begin
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
            if (filt_flip) begin
                filt_clk_reg <= ~filt_clk_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with timeout. Outputs are registered; pulses default low
    // every cycle so each one lasts exactly one cycle.
    // ------------------------------------------------------------------
    state_t        state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          parity_reg;
    logic [TW-1:0] timeout_cnt_reg;
    logic [7:0]    scan_code_reg;
    logic          scan_valid_reg;
    logic          parity_err_reg;
    logic          frame_err_reg;

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            timeout_cnt_reg <= '0;
            scan_code_reg   <= '0;
            scan_valid_reg  <= 1'b0;
            parity_err_reg  <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            scan_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;

            if (state_reg == IDLE || fall_reg) begin
                timeout_cnt_reg <= '0;
            end else if (timeout_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                // Stalled mid-frame: drop the partial byte.
                timeout_cnt_reg <= '0;
                state_reg       <= IDLE;
                shift_reg       <= '0;
                frame_err_reg   <= 1'b1;
            end else begin
                timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            end

            if (fall_reg) begin
                case (state_reg)
                    IDLE: begin
                        if (!data_synced) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_synced, shift_reg[7:1]};
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end
                    PARITY: begin
                        parity_reg <= data_synced;
                        state_reg  <= STOP;
                    end
                    STOP: begin
                        state_reg <= IDLE;
                        if (!data_synced) begin
                            frame_err_reg <= 1'b1;
                        end else if (^{shift_reg, parity_reg} == 1'b0) begin
                            // Even count of ones over data+parity.
                            parity_err_reg <= 1'b1;
                        end else begin
                            scan_code_reg  <= shift_reg;
                            scan_valid_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign SCAN_CODE  = scan_code_reg;
    assign SCAN_VALID = scan_valid_reg;
    assign PARITY_ERR = parity_err_reg;
    assign FRAME_ERR  = frame_err_reg;

endmodule
